// File: rtl/vad_energy_pkg.sv
// Shared definitions for the frame-energy voice activity detector:
// FSM state codes and the accumulator width helper.
package vad_energy_pkg;

    localparam logic [1:0] ST_SILENT = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_HANG   = 2'd2;

    // Width that holds FRAME_LEN saturated magnitudes without overflow
    function automatic int unsigned acc_bw(input int unsigned data_bw,
                                           input int unsigned frame_len);
        return data_bw - 1 + $clog2(frame_len);
    endfunction

endpackage

// File: rtl/vad_energy_if.sv
// Sample/threshold inputs and energy/vad outputs of the VAD block.
interface vad_energy_if
    import vad_energy_pkg::*;
#(
    parameter int unsigned DATA_BW   = 16,
    parameter int unsigned FRAME_LEN = 256
);
    localparam int unsigned ACC_BW = acc_bw(DATA_BW, FRAME_LEN);

    logic                      en_i;
    logic                      valid_i;
    logic signed [DATA_BW-1:0] data_i;
    logic        [ACC_BW-1:0]  thresh_i;
    logic        [ACC_BW-1:0]  energy_o;
    logic                      energy_valid_o;
    logic                      vad_o;

    modport master (
        output en_i, valid_i, data_i, thresh_i,
        input  energy_o, energy_valid_o, vad_o
    );

    modport slave (
        input  en_i, valid_i, data_i, thresh_i,
        output energy_o, energy_valid_o, vad_o
    );

endinterface

// File: rtl/vad_energy_abs_sat.sv
// Combinational saturating absolute value: the most negative code maps to
// the largest positive magnitude so the result fits in DATA_BW-1 bits.
module vad_energy_abs_sat #(
    parameter int unsigned DATA_BW = 16
) (
    input  logic [DATA_BW-1:0] data_i,
    output logic [DATA_BW-2:0] mag_c
);

    logic [DATA_BW-2:0] low;
    logic [DATA_BW-2:0] neg_low;

    assign low     = data_i[DATA_BW-2:0];
    // Lower bits of the two's-complement negation; only the MSB would differ
    assign neg_low = ~low + (DATA_BW-1)'(1);

    always_comb begin
        mag_c = low;
        if (data_i[DATA_BW-1]) begin
            if (low == '0) mag_c = '1;
            else           mag_c = neg_low;
        end
    end

endmodule

// File: rtl/vad_energy.sv
// Frame-energy voice activity detector: sums |sample| per frame, compares to
// a threshold and holds vad_o high for a hangover of quiet frames.
module vad_energy
    import vad_energy_pkg::*;
#(
    parameter int unsigned DATA_BW     = 16,
    parameter int unsigned FRAME_LEN   = 256,
    parameter int unsigned HANG_FRAMES = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    vad_energy_if.slave  bus
);

    localparam int unsigned ACC_BW  = acc_bw(DATA_BW, FRAME_LEN);
    localparam int unsigned CNT_BW  = $clog2(FRAME_LEN);
    localparam int unsigned HANG_BW = (HANG_FRAMES > 1) ? $clog2(HANG_FRAMES) : 1;

    logic [ACC_BW-1:0]  acc_q,    acc_nxt;
    logic [CNT_BW-1:0]  cnt_q,    cnt_nxt;
    logic [1:0]         state_q,  state_nxt;
    logic [HANG_BW-1:0] hang_q,   hang_nxt;
    logic [ACC_BW-1:0]  energy_q, energy_nxt;
    logic               ev_q,     ev_nxt;
    logic               vad_q,    vad_nxt;

    logic [DATA_BW-2:0] mag;
    logic [ACC_BW-1:0]  sum;
    logic               accept;
    logic               frame_end;
    logic               loud;

    vad_energy_abs_sat #(.DATA_BW(DATA_BW)) u_abs_sat (
        .data_i (bus.data_i),
        .mag_c  (mag)
    );

    assign accept    = bus.en_i & bus.valid_i;
    assign frame_end = accept && (cnt_q == CNT_BW'(FRAME_LEN - 1));
    assign sum       = acc_q + ACC_BW'(mag);
    assign loud      = (sum > bus.thresh_i);

    // Next-state: counter, accumulator, hangover FSM and outputs
    always_comb begin
        acc_nxt    = acc_q;
        cnt_nxt    = cnt_q;
        state_nxt  = state_q;
        hang_nxt   = hang_q;
        energy_nxt = energy_q;
        ev_nxt     = 1'b0;

        if (!bus.en_i) begin
            acc_nxt   = '0;
            cnt_nxt   = '0;
            hang_nxt  = '0;
            state_nxt = ST_SILENT;
        end else begin
            case (state_q)
                ST_SILENT, ST_ACTIVE, ST_HANG: ;
                default: state_nxt = ST_SILENT;
            endcase
            if (accept) begin
                cnt_nxt = cnt_q + CNT_BW'(1);
                acc_nxt = sum;
            end
            if (frame_end) begin
                acc_nxt    = '0;
                energy_nxt = sum;
                ev_nxt     = 1'b1;
                case (state_q)
                    ST_SILENT: if (loud) state_nxt = ST_ACTIVE;
                    ST_ACTIVE: begin
                        if (!loud) begin
                            if (HANG_FRAMES == 0) begin
                                state_nxt = ST_SILENT;
                            end else begin
                                state_nxt = ST_HANG;
                                hang_nxt  = HANG_BW'(HANG_FRAMES - 1);
                            end
                        end
                    end
                    ST_HANG: begin
                        if (loud)              state_nxt = ST_ACTIVE;
                        else if (hang_q == '0) state_nxt = ST_SILENT;
                        else                   hang_nxt  = hang_q - HANG_BW'(1);
                    end
                    default: state_nxt = ST_SILENT;
                endcase
            end
        end

        vad_nxt = (state_nxt != ST_SILENT);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= ST_SILENT;
            hang_q   <= '0;
            energy_q <= '0;
            ev_q     <= 1'b0;
            vad_q    <= 1'b0;
        end else begin
            acc_q    <= acc_nxt;
            cnt_q    <= cnt_nxt;
            state_q  <= state_nxt;
            hang_q   <= hang_nxt;
            energy_q <= energy_nxt;
            ev_q     <= ev_nxt;
            vad_q    <= vad_nxt;
        end
    end

    assign bus.energy_o       = energy_q;
    assign bus.energy_valid_o = ev_q;
    assign bus.vad_o          = vad_q;

endmodule
